alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station and issue scheduler for the integer ALU.
- Buffers decoded ALU-class instructions (ARITH, ARITHI, BR, JAL, JALR, LUI, AUIPC) and tracks operand readiness by snooping the two result buses (ALU and load/store buffer).
- Each cycle, dispatches at most one fully-ready entry to the ALU.
- Sits between the decoder/ROB allocation stage and the ALU; it is the only driver of the ALU's input bundle.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_IDX_W, 4, log2(RS_SIZE).
- ROB_POS_W, 4, ROB tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low = stall.
- rollback  in  1  branch mispredict flush.
- issue  in  1  decoder writes a new entry this cycle.
- issue_opcode  in  7  opcode.
- issue_funct3  in  3  funct3.
- issue_funct7  in  1  funct7 bit 5 (SUB/SRA select).
- issue_rs1_rdy  in  1  rs1 value valid.
- issue_rs1_val  in  32  rs1 value (valid when issue_rs1_rdy=1).
- issue_rs1_tag  in  ROB_POS_W  producing ROB entry (used when issue_rs1_rdy=0).
- issue_rs2_rdy  in  1  rs2 value valid.
- issue_rs2_val  in  32  rs2 value (valid when issue_rs2_rdy=1).
- issue_rs2_tag  in  ROB_POS_W  producing ROB entry (used when issue_rs2_rdy=0).
- issue_imm  in  32  immediate.
- issue_pc  in  32  instruction PC.
- issue_rob_pos  in  ROB_POS_W  destination ROB tag.
- rs_full  out  1  registered; decoder must not assert issue while high.
- alu_result  in  1  ALU broadcast valid.
- alu_result_rob_pos  in  ROB_POS_W  ALU broadcast tag.
- alu_result_val  in  32  ALU broadcast value.
- lsb_result  in  1  LSB broadcast valid.
- lsb_result_rob_pos  in  ROB_POS_W  LSB broadcast tag.
- lsb_result_val  in  32  LSB broadcast value.
- alu_en  out  1  dispatch valid, registered.
- alu_opcode  out  7  dispatched opcode, registered.
- alu_funct3  out  3  dispatched funct3, registered.
- alu_funct7  out  1  dispatched funct7 bit, registered.
- alu_val1  out  32  dispatched rs1 value, registered.
- alu_val2  out  32  dispatched rs2 value, registered.
- alu_imm  out  32  dispatched immediate, registered.
- alu_pc  out  32  dispatched PC, registered.
- alu_rob_pos  out  ROB_POS_W  dispatched ROB tag, registered.

Behaviour:
- Entry state: busy, opcode, funct3, funct7, imm, pc, rob_pos, and per operand {rdy, val, tag}.
- Reset (async, rst=1): all busy=0. alu_en=0, rs_full=0, and all other outputs 0.
- Priority on each posedge: rst > rollback > ~rdy > normal.
- rollback=1: clear every busy bit; alu_en<=0, rs_full<=0. The same-cycle issue is discarded.
- ~rdy: all state and outputs hold. alu_en keeps its value; the ALU ignores it while stalled, so no dispatch is lost or duplicated.
- Alloc: issue=1 writes the lowest-index free entry. If no entry is free, the issue is dropped; this is a protocol violation and the bench flags it.
- Issue-time forwarding: if an issuing operand has rdy=0 and its tag matches a valid broadcast this same cycle, store it as ready with the broadcast value.
- Wakeup: every busy entry with operand rdy=0 compares its tag against both buses. On a match it sets rdy=1 and captures the value.
  - If both buses match the same tag, the ALU bus wins.
  - A single broadcast may wake both operands of one entry and any number of entries.
- Wakeup is visible to selection one edge later: selection uses registered operand rdy only.
- Select: among busy entries with both rdy=1, choose the lowest index.
- Dispatch: at the edge the entry is selected, load all alu_* outputs from it, set alu_en<=1 and clear that entry's busy. With no ready entry, alu_en<=0 and the other alu_* outputs hold.
- Latency:
  - An entry issued at edge N with both operands ready has alu_en=1 after edge N+1.
  - An operand broadcast in the cycle ending at edge M leads to dispatch no earlier than edge M+1.
- Same-cycle alloc and dispatch: a slot freed at edge N is reusable by an issue at edge N+1, not N.
- rs_full: after each edge, rs_full = (busy count >= RS_SIZE-1). The one-entry slack covers the decoder's one-cycle reaction lag.
- Single-source opcodes: the decoder presents issue_rs2_rdy=1 (ARITHI, JALR, LUI, AUIPC, JAL) and issue_rs1_rdy=1 (LUI, AUIPC, JAL). This block does no opcode-based masking.
- Tags are compared by full equality. Entries never self-match, because a destination tag is not broadcast before dispatch.

Test Plan:
- Reset: rst pulse mid-cycle -> alu_en=0 and rs_full=0 immediately, no clk needed. Issue ADD(5,7, rob 2) at edge 1 -> alu_en=1, val1=5, val2=7, rob_pos=2 after edge 2.
- Wakeup: issue SUB (rs1 tag 3 not ready, rs2=1) at edge 1. ALU broadcast {3, 0x10} in the cycle ending at edge 4 -> dispatch after edge 5 with val1=0x10, val2=1, funct7=1.
- Issue-time forwarding and ordering: issue BEQ with both operands tag 6 in the same cycle that LSB broadcasts {6, 0xAB} -> both operands ready, dispatch next edge with val1=val2=0xAB. Two ready entries at idx 0 and 3 -> idx 0 dispatched first, idx 3 on the following edge.
- Full: fill 15 entries, none ready -> rs_full=1 after the 15th issue. A broadcast waking one entry -> dispatch, then rs_full=0 after the following edge.
- Flush and stall: 8 busy entries, assert rollback -> alu_en=0 and rs_full=0 next edge, no dispatch afterwards until new issues. Hold rdy=0 for 3 cycles with alu_en=1 -> all outputs stable, and entries woken during the stall are not dispatched until rdy=1.

Source files
------------

// File: rtl/alu_rs_if.sv
// Bundle between the decoder/ROB stage, the result buses and the ALU,
// as seen by the ALU reservation station.
interface alu_rs_if #(
  parameter int ROB_POS_W = 4
);
  logic                 rdy;
  logic                 rollback;

  logic                 issue;
  logic [6:0]           issue_opcode;
  logic [2:0]           issue_funct3;
  logic                 issue_funct7;
  logic                 issue_rs1_rdy;
  logic [31:0]          issue_rs1_val;
  logic [ROB_POS_W-1:0] issue_rs1_tag;
  logic                 issue_rs2_rdy;
  logic [31:0]          issue_rs2_val;
  logic [ROB_POS_W-1:0] issue_rs2_tag;
  logic [31:0]          issue_imm;
  logic [31:0]          issue_pc;
  logic [ROB_POS_W-1:0] issue_rob_pos;
  logic                 rs_full;

  logic                 alu_result;
  logic [ROB_POS_W-1:0] alu_result_rob_pos;
  logic [31:0]          alu_result_val;
  logic                 lsb_result;
  logic [ROB_POS_W-1:0] lsb_result_rob_pos;
  logic [31:0]          lsb_result_val;

  logic                 alu_en;
  logic [6:0]           alu_opcode;
  logic [2:0]           alu_funct3;
  logic                 alu_funct7;
  logic [31:0]          alu_val1;
  logic [31:0]          alu_val2;
  logic [31:0]          alu_imm;
  logic [31:0]          alu_pc;
  logic [ROB_POS_W-1:0] alu_rob_pos;

  modport master (
    output rdy, rollback, issue, issue_opcode, issue_funct3, issue_funct7,
           issue_rs1_rdy, issue_rs1_val, issue_rs1_tag,
           issue_rs2_rdy, issue_rs2_val, issue_rs2_tag,
           issue_imm, issue_pc, issue_rob_pos,
           alu_result, alu_result_rob_pos, alu_result_val,
           lsb_result, lsb_result_rob_pos, lsb_result_val,
    input  rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
           alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
  );

  modport slave (
    input  rdy, rollback, issue, issue_opcode, issue_funct3, issue_funct7,
           issue_rs1_rdy, issue_rs1_val, issue_rs1_tag,
           issue_rs2_rdy, issue_rs2_val, issue_rs2_tag,
           issue_imm, issue_pc, issue_rob_pos,
           alu_result, alu_result_rob_pos, alu_result_val,
           lsb_result, lsb_result_rob_pos, lsb_result_val,
    output rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
           alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
  );
endinterface

// File: rtl/alu_rs.sv
// Integer ALU reservation station: buffers ALU-class instructions, snoops the
// ALU and LSB result buses for operands, and dispatches one ready entry per cycle.
module alu_rs #(
  parameter int RS_SIZE   = 16,
  parameter int RS_IDX_W  = 4,
  parameter int ROB_POS_W = 4
) (
  input logic     clk,
  input logic     rst,
  alu_rs_if.slave bus
);

  typedef struct packed {
    logic                 rdy;
    logic [31:0]          val;
  } opnd_t;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [ROB_POS_W-1:0] rob_pos;
    opnd_t                op1;
    logic [ROB_POS_W-1:0] tag1;
    opnd_t                op2;
    logic [ROB_POS_W-1:0] tag2;
  } entry_t;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7;
    logic [31:0]          val1;
    logic [31:0]          val2;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [ROB_POS_W-1:0] rob_pos;
  } dispatch_t;

  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] busy_q, busy_d;
  dispatch_t          out_q, out_d;
  logic               alu_en_q, alu_en_d;
  logic               rs_full_q, rs_full_d;

  logic                sel_found, free_found;
  logic [RS_IDX_W-1:0] sel_idx, free_idx;
  logic [RS_IDX_W:0]   busy_cnt;

  // An operand still waiting takes the broadcast value; the ALU bus wins a tie.
  function automatic opnd_t snoop(input opnd_t cur, input logic [ROB_POS_W-1:0] tag,
                                  input logic a_v, input logic [ROB_POS_W-1:0] a_tag,
                                  input logic [31:0] a_val,
                                  input logic l_v, input logic [ROB_POS_W-1:0] l_tag,
                                  input logic [31:0] l_val);
    opnd_t res;
    res = cur;
    if (!cur.rdy) begin
      if (a_v && a_tag == tag)      res = '{rdy: 1'b1, val: a_val};
      else if (l_v && l_tag == tag) res = '{rdy: 1'b1, val: l_val};
    end
    return res;
  endfunction

  // Selection looks at registered readiness only, so a wakeup dispatches one edge later.
  always_comb begin
    // NOTE: every variable written here gets a default first, or a latch is inferred.
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!sel_found && busy_q[i] && ent_q[i].op1.rdy && ent_q[i].op2.rdy) begin
        sel_found = 1'b1;
        sel_idx   = RS_IDX_W'(i);
      end
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d   = busy_q;
    ent_d    = ent_q;
    out_d    = out_q;
    alu_en_d = 1'b0;
    if (bus.rollback) begin
      busy_d = '0;
    end else if (!bus.rdy) begin
      alu_en_d = alu_en_q;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          ent_d[i].op1 = snoop(ent_q[i].op1, ent_q[i].tag1,
                               bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                               bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
          ent_d[i].op2 = snoop(ent_q[i].op2, ent_q[i].tag2,
                               bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                               bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
        end
      end
      if (sel_found) begin
        out_d.opcode  = ent_q[sel_idx].opcode;
        out_d.funct3  = ent_q[sel_idx].funct3;
        out_d.funct7  = ent_q[sel_idx].funct7;
        out_d.val1    = ent_q[sel_idx].op1.val;
        out_d.val2    = ent_q[sel_idx].op2.val;
        out_d.imm     = ent_q[sel_idx].imm;
        out_d.pc      = ent_q[sel_idx].pc;
        out_d.rob_pos = ent_q[sel_idx].rob_pos;
        alu_en_d      = 1'b1;
        busy_d[sel_idx] = 1'b0;
      end
      // Allocation uses the pre-dispatch busy mask: a freed slot is reusable next edge.
      if (bus.issue && free_found) begin
        ent_d[free_idx].opcode  = bus.issue_opcode;
        ent_d[free_idx].funct3  = bus.issue_funct3;
        ent_d[free_idx].funct7  = bus.issue_funct7;
        ent_d[free_idx].imm     = bus.issue_imm;
        ent_d[free_idx].pc      = bus.issue_pc;
        ent_d[free_idx].rob_pos = bus.issue_rob_pos;
        ent_d[free_idx].tag1    = bus.issue_rs1_tag;
        ent_d[free_idx].tag2    = bus.issue_rs2_tag;
        ent_d[free_idx].op1 = snoop('{rdy: bus.issue_rs1_rdy, val: bus.issue_rs1_val},
                                    bus.issue_rs1_tag,
                                    bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                                    bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
        ent_d[free_idx].op2 = snoop('{rdy: bus.issue_rs2_rdy, val: bus.issue_rs2_val},
                                    bus.issue_rs2_tag,
                                    bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                                    bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
        busy_d[free_idx] = 1'b1;
      end
    end
    busy_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) busy_cnt = busy_cnt + (RS_IDX_W+1)'(busy_d[i]);
    rs_full_d = (busy_cnt >= (RS_IDX_W+1)'(RS_SIZE - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      out_q     <= '0;
      alu_en_q  <= 1'b0;
      rs_full_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      out_q     <= out_d;
      alu_en_q  <= alu_en_d;
      rs_full_q <= rs_full_d;
    end
  end

  // NOTE: entry payload is not reset; busy_q gates every use, so the array stays plain storage.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign bus.rs_full     = rs_full_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_opcode  = out_q.opcode;
  assign bus.alu_funct3  = out_q.funct3;
  assign bus.alu_funct7  = out_q.funct7;
  assign bus.alu_val1    = out_q.val1;
  assign bus.alu_val2    = out_q.val2;
  assign bus.alu_imm     = out_q.imm;
  assign bus.alu_pc      = out_q.pc;
  assign bus.alu_rob_pos = out_q.rob_pos;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: reset, dispatch latency, wakeup, forwarding,
// ordering, full threshold, rollback and stall.
module tb_alu_rs;
  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  alu_rs_if #(.ROB_POS_W(4)) bus ();

  alu_rs #(.RS_SIZE(16), .RS_IDX_W(4), .ROB_POS_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.issue      = 1'b0;
    bus.rollback   = 1'b0;
    bus.alu_result = 1'b0;
    bus.lsb_result = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_alu_en", 32'(bus.alu_en), 0);
    chk("rst_rs_full", 32'(bus.rs_full), 0);
    chk("rst_val1", bus.alu_val1, 0);
    chk("rst_rob_pos", 32'(bus.alu_rob_pos), 0);
    rst = 1'b0;
  endtask

  task automatic do_issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                          input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    chk("issue_while_full", 32'(bus.rs_full), 0);
    bus.issue         = 1'b1;
    bus.issue_opcode  = op;
    bus.issue_funct3  = f3;
    bus.issue_funct7  = f7;
    bus.issue_rs1_rdy = r1;
    bus.issue_rs1_val = v1;
    bus.issue_rs1_tag = t1;
    bus.issue_rs2_rdy = r2;
    bus.issue_rs2_val = v2;
    bus.issue_rs2_tag = t2;
    bus.issue_imm     = imm;
    bus.issue_pc      = pc;
    bus.issue_rob_pos = rob;
  endtask

  task automatic alu_bcast(input logic [3:0] tag, input logic [31:0] val);
    bus.alu_result         = 1'b1;
    bus.alu_result_rob_pos = tag;
    bus.alu_result_val     = val;
  endtask

  task automatic lsb_bcast(input logic [3:0] tag, input logic [31:0] val);
    bus.lsb_result         = 1'b1;
    bus.lsb_result_rob_pos = tag;
    bus.lsb_result_val     = val;
  endtask

  initial begin
    rst = 1'b0;
    bus.rdy = 1'b1;
    bus.rollback = 1'b0;
    bus.issue = 1'b0;
    bus.issue_opcode = '0; bus.issue_funct3 = '0; bus.issue_funct7 = 1'b0;
    bus.issue_rs1_rdy = 1'b0; bus.issue_rs1_val = '0; bus.issue_rs1_tag = '0;
    bus.issue_rs2_rdy = 1'b0; bus.issue_rs2_val = '0; bus.issue_rs2_tag = '0;
    bus.issue_imm = '0; bus.issue_pc = '0; bus.issue_rob_pos = '0;
    bus.alu_result = 1'b0; bus.alu_result_rob_pos = '0; bus.alu_result_val = '0;
    bus.lsb_result = 1'b0; bus.lsb_result_rob_pos = '0; bus.lsb_result_val = '0;

    // Reset mid-cycle, then ADD 5+7 dispatched one edge after issue.
    #2;
    pulse_reset();
    do_issue(7'h33, 3'd0, 1'b0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 32'd0, 32'h40, 4'd2);
    tick();
    chk("add_not_yet", 32'(bus.alu_en), 0);
    tick();
    chk("add_en", 32'(bus.alu_en), 1);
    chk("add_val1", bus.alu_val1, 32'd5);
    chk("add_val2", bus.alu_val2, 32'd7);
    chk("add_rob", 32'(bus.alu_rob_pos), 2);
    chk("add_opcode", 32'(bus.alu_opcode), 32'h33);
    tick();
    chk("add_en_drop", 32'(bus.alu_en), 0);
    chk("add_val1_hold", bus.alu_val1, 32'd5);

    // Wakeup: SUB waits on tag 3; both buses broadcast tag 3, ALU value wins.
    pulse_reset();
    do_issue(7'h33, 3'd0, 1'b1, 1'b0, 32'd0, 4'd3, 1'b1, 32'd1, 4'd0, 32'd0, 32'h80, 4'd4);
    tick();
    tick();
    tick();
    chk("sub_waiting", 32'(bus.alu_en), 0);
    alu_bcast(4'd3, 32'h10);
    lsb_bcast(4'd3, 32'h99);
    tick();
    chk("sub_wake_not_visible", 32'(bus.alu_en), 0);
    tick();
    chk("sub_en", 32'(bus.alu_en), 1);
    chk("sub_val1", bus.alu_val1, 32'h10);
    chk("sub_val2", bus.alu_val2, 32'd1);
    chk("sub_funct7", 32'(bus.alu_funct7), 1);
    chk("sub_rob", 32'(bus.alu_rob_pos), 4);

    // Issue-time forwarding from the LSB bus to both operands.
    pulse_reset();
    do_issue(7'h63, 3'd0, 1'b0, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd6, 32'd8, 32'h100, 4'd7);
    lsb_bcast(4'd6, 32'hAB);
    tick();
    tick();
    chk("fwd_en", 32'(bus.alu_en), 1);
    chk("fwd_val1", bus.alu_val1, 32'hAB);
    chk("fwd_val2", bus.alu_val2, 32'hAB);
    chk("fwd_pc", bus.alu_pc, 32'h100);
    chk("fwd_imm", bus.alu_imm, 32'd8);

    // Ordering: idx 0 and 3 wait on tag 9, woken by one broadcast.
    pulse_reset();
    do_issue(7'h33, 3'd0, 1'b0, 1'b0, 32'd0, 4'd9,  1'b1, 32'd0, 4'd0, 32'd0, 32'd0, 4'd1);
    tick();
    do_issue(7'h33, 3'd0, 1'b0, 1'b0, 32'd0, 4'd10, 1'b1, 32'd1, 4'd0, 32'd0, 32'd0, 4'd2);
    tick();
    do_issue(7'h33, 3'd0, 1'b0, 1'b0, 32'd0, 4'd10, 1'b1, 32'd2, 4'd0, 32'd0, 32'd0, 4'd3);
    tick();
    do_issue(7'h33, 3'd0, 1'b0, 1'b0, 32'd0, 4'd9,  1'b1, 32'd3, 4'd0, 32'd0, 32'd0, 4'd4);
    tick();
    alu_bcast(4'd9, 32'h55);
    tick();
    tick();
    chk("ord_first_rob", 32'(bus.alu_rob_pos), 1);
    chk("ord_first_val1", bus.alu_val1, 32'h55);
    tick();
    chk("ord_second_en", 32'(bus.alu_en), 1);
    chk("ord_second_rob", 32'(bus.alu_rob_pos), 4);
    chk("ord_second_val2", bus.alu_val2, 32'd3);
    tick();
    chk("ord_idle", 32'(bus.alu_en), 0);

    // Full: 15 waiting entries; entry i waits on tag i, rob 14-i.
    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      do_issue(7'h13, 3'd0, 1'b0, 1'b0, 32'd0, 4'(i), 1'b1, 32'd0, 4'd0,
               32'd0, 32'd0, 4'(14 - i));
      tick();
      if (i == 13) chk("full_at_14", 32'(bus.rs_full), 0);
      if (i == 14) chk("full_at_15", 32'(bus.rs_full), 1);
    end
    lsb_bcast(4'd5, 32'h77);
    tick();
    chk("full_after_wake", 32'(bus.rs_full), 1);
    tick();
    chk("full_disp_en", 32'(bus.alu_en), 1);
    chk("full_disp_rob", 32'(bus.alu_rob_pos), 9);
    chk("full_disp_val1", bus.alu_val1, 32'h77);
    chk("full_cleared", 32'(bus.rs_full), 0);
    do_issue(7'h33, 3'd0, 1'b0, 1'b1, 32'h1234, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0, 4'd15);
    tick();
    chk("reuse_full_again", 32'(bus.rs_full), 1);
    tick();
    chk("reuse_rob", 32'(bus.alu_rob_pos), 15);
    chk("reuse_val1", bus.alu_val1, 32'h1234);
    chk("reuse_not_full", 32'(bus.rs_full), 0);

    // Rollback over 8 busy entries, one of them ready; same-cycle issue discarded.
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      do_issue(7'h33, 3'd0, 1'b0, 1'b0, 32'd0, 4'd13, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0, 4'(i));
      tick();
    end
    do_issue(7'h33, 3'd0, 1'b0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd0, 32'd0, 4'd7);
    tick();
    do_issue(7'h33, 3'd0, 1'b0, 1'b1, 32'h42, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0, 4'd8);
    bus.rollback = 1'b1;
    tick();
    chk("rb_alu_en", 32'(bus.alu_en), 0);
    chk("rb_rs_full", 32'(bus.rs_full), 0);
    alu_bcast(4'd13, 32'h3);
    tick();
    chk("rb_no_disp_1", 32'(bus.alu_en), 0);
    tick();
    chk("rb_no_disp_2", 32'(bus.alu_en), 0);
    tick();
    chk("rb_no_disp_3", 32'(bus.alu_en), 0);
    do_issue(7'h33, 3'd0, 1'b0, 1'b1, 32'd6, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0, 4'd9);
    tick();
    tick();
    chk("rb_new_en", 32'(bus.alu_en), 1);
    chk("rb_new_rob", 32'(bus.alu_rob_pos), 9);

    // Stall: hold rdy low three edges with alu_en=1 and another entry just woken.
    pulse_reset();
    do_issue(7'h33, 3'd0, 1'b0, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0, 4'd3);
    tick();
    do_issue(7'h33, 3'd0, 1'b0, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 32'd0, 32'd0, 4'd1);
    tick();
    do_issue(7'h33, 3'd0, 1'b0, 1'b1, 32'h33, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0, 4'd2);
    alu_bcast(4'd9, 32'h99);
    tick();
    chk("stall_pre_en", 32'(bus.alu_en), 1);
    chk("stall_pre_rob", 32'(bus.alu_rob_pos), 1);
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_en", 32'(bus.alu_en), 1);
      chk("stall_rob", 32'(bus.alu_rob_pos), 1);
      chk("stall_val1", bus.alu_val1, 32'h11);
      chk("stall_val2", bus.alu_val2, 32'h22);
    end
    bus.rdy = 1'b1;
    tick();
    chk("post_stall_rob", 32'(bus.alu_rob_pos), 3);
    chk("post_stall_val1", bus.alu_val1, 32'h99);
    tick();
    chk("post_stall_rob2", 32'(bus.alu_rob_pos), 2);
    chk("post_stall_val1b", bus.alu_val1, 32'h33);
    tick();
    chk("post_stall_idle", 32'(bus.alu_en), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
